// File: rtl/mdu_pkg.sv
// Shared op codes and default latencies for the multiply/divide unit and the E-stage decoder.
// Ops 7-10 (MADD family) are only decoded when MDU_MADD_EN is defined.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } mdu_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mult_div_unit_arith.sv
// Combinational commit-value generator: multiply, divide and (with MDU_MADD_EN) accumulate.
// o_we is low for divide by zero and for ops that never commit through this path.
module mdu_arith
  import mdu_pkg::*;
(
  input  mdu_op_e     i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [63:0] i_hilo,
  output logic [63:0] o_result,
  output logic        o_we
);

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_div_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  // Low 64 bits of a 64x64 product of sign-extended operands equal the signed 32x32 product.
  assign w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
  assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

  // Divide on magnitudes so that 0x80000000 / -1 needs no special case.
  assign w_div_signed = (i_op == OP_DIV);
  assign w_a_neg      = w_div_signed & i_a[31];
  assign w_b_neg      = w_div_signed & i_b[31];
  assign w_a_mag      = w_a_neg ? (~i_a + 32'd1) : i_a;
  assign w_b_mag      = (i_b == 32'd0) ? 32'd1 : (w_b_neg ? (~i_b + 32'd1) : i_b);
  assign w_q_mag      = w_a_mag / w_b_mag;
  assign w_r_mag      = w_a_mag % w_b_mag;
  assign w_quot       = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_rem        = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    o_result = '0;
    o_we     = 1'b0;
    case (i_op)
      OP_MULT:  begin o_result = w_prod_s;       o_we = 1'b1;               end
      OP_MULTU: begin o_result = w_prod_u;       o_we = 1'b1;               end
      OP_DIV,
      OP_DIVU:  begin o_result = {w_rem, w_quot}; o_we = (i_b != 32'd0);    end
`ifdef MDU_MADD_EN
      OP_MADD:  begin o_result = i_hilo + w_prod_s; o_we = 1'b1;            end
      OP_MADDU: begin o_result = i_hilo + w_prod_u; o_we = 1'b1;            end
      OP_MSUB:  begin o_result = i_hilo - w_prod_s; o_we = 1'b1;            end
      OP_MSUBU: begin o_result = i_hilo - w_prod_u; o_we = 1'b1;            end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: owns HI/LO, operand latches and the busy counter.
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU (ops 7-10).
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  mdu_op_e          r_op;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic        w_accept;
  logic        w_is_mul;
  logic        w_is_div;
  logic [63:0] w_result;
  logic        w_we;

  assign busy     = (r_cnt != '0);
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign w_accept = start & ~flush & ~busy;
  assign w_is_div = (op == OP_DIV) || (op == OP_DIVU);
`ifdef MDU_MADD_EN
  assign w_is_mul = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
                    (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`else
  assign w_is_mul = (op == OP_MULT) || (op == OP_MULTU);
`endif

  mdu_arith u_arith (
    .i_op     (r_op),
    .i_a      (r_a),
    .i_b      (r_b),
    .i_hilo   ({r_hi, r_lo}),
    .o_result (w_result),
    .o_we     (w_we)
  );

  // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: operand latches are cleared too, discarding any pending result.
      r_cnt <= '0;
      r_op  <= OP_NONE;
      r_a   <= '0;
      r_b   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else if (busy) begin
      // In-flight ops finish regardless of flush; they are older than the excepting instruction.
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1) && w_we) begin
        r_hi <= w_result[63:32];
        r_lo <= w_result[31:0];
      end
    end else if (w_accept) begin
      if (w_is_mul || w_is_div) begin
        r_op  <= mdu_op_e'(op);
        r_a   <= a;
        r_b   <= b;
        r_cnt <= w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (op == OP_MTHI) begin
        r_hi <= a;
      end else if (op == OP_MTLO) begin
        r_lo <= a;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table plus hand-written corner sequences.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one start pulse at a negedge; return the number of busy cycles seen afterwards.
  task automatic run_op(input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb,
                        input logic fl, output int cyc);
    @(negedge clk);
    start = 1'b1; op = o; a = va; b = vb; flush = fl;
    @(negedge clk);
    start = 1'b0; flush = 1'b0; op = 4'd0;
    cyc = 0;
    while (busy && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic preload(input logic [31:0] vh, input logic [31:0] vl);
    int c;
    run_op(OP_MTHI, vh, 32'd0, 1'b0, c);
    run_op(OP_MTLO, vl, 32'd0, 1'b0, c);
  endtask

  initial begin
    int cyc;
    reset = 1'b1; start = 1'b0; op = 4'd0; a = '0; b = '0; flush = 1'b0;

    vecs.push_back('{"mult_neg1x2",    OP_MULT,  32'hFFFFFFFF, 32'd2,        0, 0, 32'hFFFFFFFF, 32'hFFFFFFFE, 5});
    vecs.push_back('{"multu_ffx2",     OP_MULTU, 32'hFFFFFFFF, 32'd2,        0, 0, 32'h00000001, 32'hFFFFFFFE, 5});
    vecs.push_back('{"multu_ffxff",    OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFE, 32'h00000001, 5});
    vecs.push_back('{"mult_neg1xneg1", OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'h00000000, 32'h00000001, 5});
    vecs.push_back('{"mult_min_sq",    OP_MULT,  32'h80000000, 32'h80000000, 0, 0, 32'h40000000, 32'h00000000, 5});
    vecs.push_back('{"div_neg7_2",     OP_DIV,   32'hFFFFFFF9, 32'd2,        0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10});
    vecs.push_back('{"div_7_neg2",     OP_DIV,   32'd7,        32'hFFFFFFFE, 0, 0, 32'h00000001, 32'hFFFFFFFD, 10});
    vecs.push_back('{"divu_7_2",       OP_DIVU,  32'd7,        32'd2,        0, 0, 32'h00000001, 32'h00000003, 10});
    vecs.push_back('{"divu_big",       OP_DIVU,  32'hFFFFFFF9, 32'd2,        0, 0, 32'h00000001, 32'h7FFFFFFC, 10});
    vecs.push_back('{"div_by_zero",    OP_DIV,   32'd5,        32'd0,    32'h11, 32'h22, 32'h11, 32'h22,      10});
    vecs.push_back('{"div_min_neg1",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 0, 0, 32'h00000000, 32'h80000000, 10});
    vecs.push_back('{"none_op",        OP_NONE,  32'd9,        32'd9,    32'h5, 32'h6, 32'h5, 32'h6,          0});
    vecs.push_back('{"undef_op11",     4'd11,    32'd9,        32'd9,    32'h5, 32'h6, 32'h5, 32'h6,          0});
    vecs.push_back('{"mthi",           OP_MTHI,  32'hCAFE0001, 32'd0,    32'h5, 32'h6, 32'hCAFE0001, 32'h6,   0});
    vecs.push_back('{"mtlo",           OP_MTLO,  32'hBEEF0002, 32'd0,    32'h5, 32'h6, 32'h5, 32'hBEEF0002,   0});

    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    foreach (vecs[i]) begin
      preload(vecs[i].pre_hi, vecs[i].pre_lo);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, cyc);
      check({vecs[i].name, "_cycles"}, cyc, vecs[i].exp_cyc);
      check({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
      check({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
    end

    // start together with flush is dropped
    preload(32'hA, 32'hB);
    run_op(OP_MULT, 32'd3, 32'd4, 1'b1, cyc);
    check("flush_mult_cycles", cyc, 0);
    check("flush_mult_hi", hi, 32'hA);
    check("flush_mult_lo", lo, 32'hB);
    run_op(OP_MTHI, 32'h1234, 32'd0, 1'b1, cyc);
    check("flush_mthi_hi", hi, 32'hA);

    // start while busy is ignored: MULT 2x3 runs its full 5 cycles, DIVU 100/7 is dropped
    preload(32'd0, 32'd0);
    @(negedge clk);
    start = 1'b1; op = OP_MULT; a = 32'd2; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    cyc = busy ? 1 : 0;
    @(negedge clk);
    if (busy) cyc++;
    start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    while (busy && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
    check("busy_start_cycles", cyc, 5);
    check("busy_start_hi", hi, 32'd0);
    check("busy_start_lo", lo, 32'd6);

    // reset in busy cycle 4 of DIVU 100/7 discards the pending result
    preload(32'h55, 32'h66);
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_mid_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_hi", hi, 32'd0);
    check("rst_mid_lo", lo, 32'd0);
    repeat (15) @(negedge clk);
    check("rst_no_commit_hi", hi, 32'd0);
    check("rst_no_commit_lo", lo, 32'd0);

`ifdef MDU_MADD_EN
    preload(32'd0, 32'hFFFFFFFF);
    run_op(OP_MADDU, 32'd1, 32'd1, 1'b0, cyc);
    check("maddu_cycles", cyc, 5);
    check("maddu_hi", hi, 32'd1);
    check("maddu_lo", lo, 32'd0);
    run_op(OP_MSUB, 32'd1, 32'd1, 1'b0, cyc);
    check("msub_cycles", cyc, 5);
    check("msub_hi", hi, 32'd0);
    check("msub_lo", lo, 32'hFFFFFFFF);
`else
    preload(32'd0, 32'hFFFFFFFF);
    run_op(OP_MADDU, 32'd1, 32'd1, 1'b0, cyc);
    check("maddu_off_cycles", cyc, 0);
    check("maddu_off_hi", hi, 32'd0);
    check("maddu_off_lo", lo, 32'hFFFFFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Execute-stage multiply/divide unit for the five-stage MIPS pipeline with interrupts and exceptions. It runs beside the ALU in E. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage and holds the architectural HI/LO registers read by MFHI/MFLO. It models the fixed multi-cycle latency with a busy counter that the hazard unit uses to stall D. It also drops a start request when the exception/interrupt flush is raised in the same cycle.

## Interface
- MULT_CYCLES, 5, cycles busy is high for multiply-class ops
- DIV_CYCLES, 10, cycles busy is high for divide-class ops
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  E-stage instruction is an MDU op and E is not stalled
- op  in  4  operation code (values in package)
- a  in  32  rs value, after forwarding
- b  in  32  rt value, after forwarding
- flush  in  1  exception/interrupt commit this cycle; suppresses start
- busy  out  1  computation in progress
- hi  out  32  architectural HI
- lo  out  32  architectural LO

## Operation
- Op codes:
  - 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO.
  - With the macro only: 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU.
  - Undefined codes behave as NONE.
- Accept condition: start & !flush & !busy. When start is not accepted, no state changes.
- MULT/MULTU (and MADD family) on accept:
  - Latch a and b, record op, load counter with MULT_CYCLES.
- DIV/DIVU on accept:
  - Latch a and b, record op, load counter with DIV_CYCLES.
- MTHI/MTLO on accept:
  - hi (or lo) <= a at that edge.
  - busy stays 0. No latency.
- While counter is non-zero, it decrements by 1 per cycle. At the 1→0 transition, {hi,lo} <= result from the latched operands.
- Arithmetic:
  - MULT is signed 32x32→64; MULTU is unsigned.
  - {hi,lo} = product.
  - DIV/DIVU: lo = quotient, hi = remainder.
  - Signed divide truncates toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero: full DIV_CYCLES busy period, hi and lo unchanged at commit.
- An in-flight op is never cancelled by flush. It is older than the excepting instruction and must complete.
- start while busy is ignored. The hazard unit guarantees it never happens; the bench still checks that it is ignored.
- Reset, including mid-operation: hi=0, lo=0, busy=0, counter=0, latched operands=0. The pending result is discarded.

## Timing
- Accept at edge t:
  - busy is 1 from after t through cycle t+N, where N is MULT_CYCLES or DIV_CYCLES.
  - hi and lo update at edge t+N.
  - busy falls at the same edge, so the new values are visible the cycle busy drops.
- busy is a registered output (counter != 0). It is never high combinationally on the start cycle. The hazard unit ORs start into its own stall term.
- MTHI/MTLO results are visible one cycle after the accepting edge.
- hi and lo are register outputs, with no combinational path from a, b, or op.

## Configuration
- MDU_MADD_EN defined:
  - Ops 7–10 are decoded with MULT_CYCLES latency.
  - At commit, {hi,lo} <= {hi,lo} ± product, using the hi/lo value at commit time, with 64-bit wrap-around.
  - MADD/MSUB are signed; MADDU/MSUBU are unsigned.
- MDU_MADD_EN undefined: codes 7–10 behave as NONE, so no busy and no state change.

## Structure
- Shared package mdu_pkg holds:
  - op code constants
  - default MULT_CYCLES and DIV_CYCLES
- The E-stage decoder uses the same constants.
- Sub-module mdu_arith:
  - Purely combinational.
  - Inputs: latched op, a, b, current hi/lo.
  - Outputs: the 64-bit commit value plus a write-enable, which is 0 for divide by zero.
- mult_div_unit owns the counter, operand latches, and the hi/lo registers.

## Test plan
- MULT a=0xFFFFFFFF, b=2 → busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (−7), b=2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 → lo=3, hi=1.
- DIV with hi=0x11, lo=0x22, b=0 → busy 10 cycles, hi and lo stay 0x11/0x22. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- start+flush on the same cycle with MULT 3×4 → busy stays 0, hi and lo unchanged. MTHI a=0x1234 with flush → hi unchanged.
- DIVU 100/7 started, reset asserted in busy cycle 4 → next cycle busy=0, hi=0, lo=0, and no later commit. A start (MULT) during busy → ignored.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU 1×1 → hi=1, lo=0. Then MSUB 1×1 → hi=0, lo=0xFFFFFFFF.
